// File: rtl/uart_tx_frame.sv
// UART transmit framer. Bit timing is taken from the rising edges of a
// baud-rate square wave. A frame is start, DATA_WIDTH data bits (LSB first),
// optional parity, then one or two stop bits. All outputs are registered.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  BaudIn,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  Send,
  input  logic [1:0]            ParityType,
  input  logic                  StopBits,
  output logic                  TxOut,
  output logic                  Busy,
  output logic                  Done
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP1  = 3'd5;
  localparam logic [2:0] S_STOP2  = 3'd6;

  logic [2:0]            state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  baud_q, baud_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tick;

  // One tick per rising edge of the baud square wave.
  assign tick = BaudIn & ~baud_q;

  // Next-state logic: frame sequencing, one bit per tick period.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    baud_d     = BaudIn;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (Send) begin
          // Everything needed for the frame is captured here so the host
          // may change DataIn and the config lines while the frame runs.
          shreg_d    = DataIn;
          par_en_d   = (ParityType == 2'b01) || (ParityType == 2'b10);
          par_bit_d  = (ParityType == 2'b01) ? ~^DataIn : ^DataIn;
          two_stop_d = StopBits;
          busy_d     = 1'b1;
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        // Wait for a baud edge so the start bit lasts a full bit time.
        tx_d = 1'b1;
        if (tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
          cnt_d   = CW'(1);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (cnt_q < LAST_CNT) begin
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
          end else if (par_en_q) begin
            tx_d    = par_bit_q;
            state_d = S_PARITY;
          end else begin
            tx_d    = 1'b1;
            state_d = S_STOP1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (tick) begin
          if (two_stop_q) begin
            state_d = S_STOP2;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (tick) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset drops the line to idle immediately.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      baud_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      baud_q     <= baud_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
    end
  end

  assign TxOut = tx_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: expected frames are queued when a request is
// driven and compared bit by bit as the serial line is decoded.
module tb_uart_tx_frame;

  logic       Clk;
  logic       ResetN;
  logic       BaudIn;
  logic [7:0] DataIn;
  logic       Send;
  logic [1:0] ParityType;
  logic       StopBits;
  logic       TxOut;
  logic       Busy;
  logic       Done;

  typedef struct {
    logic [15:0] bits;
    int          len;
    logic [7:0]  data;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int frames_ok = 0;
  bit mon_active = 0;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .Clk(Clk), .ResetN(ResetN), .BaudIn(BaudIn), .DataIn(DataIn),
    .Send(Send), .ParityType(ParityType), .StopBits(StopBits),
    .TxOut(TxOut), .Busy(Busy), .Done(Done)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // Baud square wave: toggles every 4 Clk, one bit = 8 Clk.
  initial begin
    BaudIn = 0;
    forever begin
      repeat (4) @(negedge Clk);
      BaudIn = ~BaudIn;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t mk_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb);
    frame_t f;
    int n;
    f.bits = '0;
    f.data = d;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    n = 9;
    if (pt == 2'b01) begin
      f.bits[n] = ~^d;  // total ones odd
      n++;
    end else if (pt == 2'b10) begin
      f.bits[n] = ^d;   // total ones even
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    if (sb) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.len = n;
    return f;
  endfunction

  // Count every Done pulse.
  initial begin
    forever begin
      @(negedge Clk);
      if (Done) done_cnt++;
    end
  end

  // Line decoder: sample mid-bit, compare with the queued frame, then
  // require Done exactly when the last stop bit ends.
  initial begin
    frame_t cur;
    int ph;
    int idx;
    cur = mk_frame(8'h00, 2'b00, 1'b0);
    ph = 0;
    forever begin
      @(negedge Clk);
      if (!ResetN) begin
        mon_active = 0;
      end else if (!mon_active) begin
        if (TxOut === 1'b0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            mon_active = 1;
            ph = 0;
          end
        end
      end else begin
        ph++;
        if ((ph % 8) == 4 && (ph / 8) < cur.len) begin
          idx = ph / 8;
          check($sformatf("txbit%0d_d%0h", idx, cur.data), {31'd0, TxOut}, {31'd0, cur.bits[idx]});
          check("busy_mid", {31'd0, Busy}, 32'd1);
          check("done_early", {31'd0, Done}, 32'd0);
        end
        if (ph == 8 * cur.len) begin
          check("done_at_end", {31'd0, Done}, 32'd1);
          frames_ok++;
          $display("frame data=%02h len=%0d complete", cur.data, cur.len);
          mon_active = 0;
        end
      end
    end
  end

  task automatic send_pulse(input logic [7:0] d, input logic [1:0] pt, input logic sb);
    @(negedge Clk);
    DataIn = d;
    ParityType = pt;
    StopBits = sb;
    Send = 1;
    exp_q.push_back(mk_frame(d, pt, sb));
    @(negedge Clk);
    Send = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || Busy) && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    int n;
    int aborted;
    aborted = 0;
    ResetN = 0;
    DataIn = 8'h00;
    Send = 0;
    ParityType = 2'b00;
    StopBits = 0;
    repeat (3) @(negedge Clk);
    #1;
    check("rst_tx", {31'd0, TxOut}, 32'd1);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    @(negedge Clk);
    ResetN = 1;
    repeat (5) @(negedge Clk);

    // 1: basic frame, no parity, one stop
    send_pulse(8'hA5, 2'b00, 1'b0);
    wait_idle();

    // 2: parity variants, config changed after accept has no effect
    send_pulse(8'h07, 2'b10, 1'b0);
    ParityType = 2'b01;
    DataIn = 8'hFF;
    wait_idle();
    send_pulse(8'h07, 2'b01, 1'b0);
    wait_idle();
    send_pulse(8'h5A, 2'b11, 1'b0);
    wait_idle();

    // 3: two stop bits
    send_pulse(8'hFF, 2'b00, 1'b1);
    StopBits = 0;
    wait_idle();
    send_pulse(8'hC3, 2'b01, 1'b1);
    wait_idle();

    // 4: Send mid-frame is ignored
    send_pulse(8'h3C, 2'b00, 1'b0);
    repeat (30) @(negedge Clk);
    DataIn = 8'h00;
    Send = 1;
    @(negedge Clk);
    Send = 0;
    wait_idle();

    // 5: Send held across two frames
    @(negedge Clk);
    DataIn = 8'h55;
    ParityType = 2'b00;
    StopBits = 0;
    Send = 1;
    exp_q.push_back(mk_frame(8'h55, 2'b00, 1'b0));
    exp_q.push_back(mk_frame(8'h55, 2'b00, 1'b0));
    n = 0;
    while (!Done && n < 500) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 500) check("held_done_timeout", 32'd1, 32'd0);
    @(negedge Clk);
    Send = 0;
    wait_idle();

    // 6: reset during data bit 3
    send_pulse(8'hA5, 2'b00, 1'b0);
    n = 0;
    while (TxOut !== 1'b0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 200) check("start_timeout", 32'd1, 32'd0);
    repeat (36) @(negedge Clk);
    ResetN = 0;
    aborted++;
    #1;
    check("midrst_tx", {31'd0, TxOut}, 32'd1);
    check("midrst_busy", {31'd0, Busy}, 32'd0);
    check("midrst_done", {31'd0, Done}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge Clk);
    ResetN = 1;
    repeat (5) @(negedge Clk);
    send_pulse(8'h96, 2'b10, 1'b0);
    wait_idle();

    // 11 frames requested, one aborted by reset
    check("done_total", done_cnt, 32'd10);
    check("frames_total", frames_ok, 32'd10);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
